biu_lsu: RTL and testbench

//  Load/store bus interface sitting downstream of the EXU ALU: takes opc_biu, the effective address and

---
 rtl/biu_lsu.sv | 169 ++++++++++++++++
 tb/tb_biu_lsu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/biu_lsu.sv
// Load/store bus interface: one word-bus access per request, with alignment check,
// byte-lane steering for stores, load extraction/extension and a bus timeout.
module biu_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  opc_biu,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] data_tobiu,
    output logic [31:0] data_biu,
    output logic        rdy_biu,
    output logic        busy,
    output logic        misalign,
    output logic        acc_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

    state_t      state_q, state_d;
    logic [2:0]  opc_q, opc_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [29:0] baddr_q, baddr_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mis_q, mis_d;
    logic        flt_q, flt_d;

    logic        valid_op, misal;
    logic [3:0]  strobe;
    logic [31:0] rep_data, lane, ld_val;

    // Request decode, evaluated on the raw inputs for the accept edge
    always_comb begin
        valid_op = (opc_biu[1:0] != 2'b00);
        misal    = ((opc_biu[1:0] == 2'b10) && addr[0]) ||
                   ((opc_biu[1:0] == 2'b11) && (addr[1:0] != 2'b00));
        strobe   = 4'b0000;
        rep_data = data_tobiu;
        case (opc_biu[1:0])
            2'b01: begin
                strobe   = 4'b0001 << addr[1:0];
                rep_data = {4{data_tobiu[7:0]}};
            end
            2'b10: begin
                strobe   = 4'b0011 << {addr[1], 1'b0};
                rep_data = {2{data_tobiu[15:0]}};
            end
            2'b11:   strobe = 4'b1111;
            default: strobe = 4'b0000;
        endcase
    end

    // Load extraction from the returned word, using the latched request
    always_comb begin
        lane   = bus_rdata >> {off_q, 3'b000};
        ld_val = lane;
        case (opc_q[1:0])
            2'b01:   ld_val = {{24{lane[7] & ~uns_q}}, lane[7:0]};
            2'b10:   ld_val = {{16{lane[15] & ~uns_q}}, lane[15:0]};
            default: ld_val = lane;
        endcase
    end

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        uns_d   = uns_q;
        off_d   = off_q;
        baddr_d = baddr_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        flt_d   = flt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opc_d   = opc_biu;
                    uns_d   = ld_unsigned;
                    off_d   = addr[1:0];
                    baddr_d = addr[31:2];
                    we_d    = valid_op && !misal && !opc_biu[2];
                    wstrb_d = opc_biu[2] ? 4'b0000 : strobe;
                    wdata_d = rep_data;
                    cnt_d   = '0;
                    mis_d   = valid_op && misal;
                    flt_d   = 1'b0;
                    state_d = (valid_op && !misal) ? REQ : FIN;
                end
            end
            REQ: begin
                if (bus_err) begin
                    flt_d   = 1'b1;
                    state_d = FIN;
                end else if (bus_ack) begin
                    if (opc_q[2]) data_d = ld_val;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (32'(cnt_q) + 32'd1 == TIMEOUT) begin
                        flt_d   = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            opc_q   <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            baddr_q <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            baddr_q <= baddr_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            flt_q   <= flt_d;
        end
    end

    assign bus_req   = (state_q == REQ);
    assign rdy_biu   = (state_q == FIN);
    assign busy      = (state_q != IDLE);
    assign misalign  = rdy_biu && mis_q;
    assign acc_fault = rdy_biu && flt_q;
    assign bus_we    = we_q;
    assign bus_addr  = {baddr_q, 2'b00};
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;
    assign data_biu  = data_q;

endmodule

// File: tb/tb_biu_lsu.sv
// Randomized scoreboard bench for biu_lsu: the driver plays requests and bus responses and
// queues the expected completion; a negedge monitor checks every rdy_biu against the queue.
module tb_biu_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, ld_unsigned = 1'b0;
    logic [2:0]  opc_biu = '0;
    logic [31:0] addr = '0, data_tobiu = '0, bus_rdata = '0;
    logic        bus_ack = 1'b0, bus_err = 1'b0;
    logic [31:0] data_biu, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        rdy_biu, busy, misalign, acc_fault, bus_req, bus_we;

    biu_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .opc_biu(opc_biu), .ld_unsigned(ld_unsigned),
        .addr(addr), .data_tobiu(data_tobiu), .data_biu(data_biu), .rdy_biu(rdy_biu),
        .busy(busy), .misalign(misalign), .acc_fault(acc_fault), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        mis;
        logic        flt;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] model_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst) begin
            if (rdy_biu) begin
                if (sb.size() == 0) begin
                    chk("rdy_unexpected", 32'(rdy_biu), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("misalign", 32'(misalign), 32'(mon_e.mis));
                    chk("acc_fault", 32'(acc_fault), 32'(mon_e.flt));
                    chk("data_biu", data_biu, mon_e.data);
                    chk("rdy_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("req_low_at_rdy", 32'(bus_req), 32'd0);
                end
            end else begin
                chk("flags_outside_rdy", 32'({misalign, acc_fault}), 32'd0);
            end
        end
    end

    // mode: 0 ack, 1 err, 2 err+ack, 3 never respond (timeout)
    task automatic do_access(input logic [2:0] op, input logic u, input logic [31:0] a,
                             input logic [31:0] wd, input int mode, input int dly,
                             input logic [31:0] rd, input bit poke);
        int          sz, nb, k, w;
        bit          valid, mis, bus_acc;
        exp_t        e;
        logic [31:0] lane, ld, strb, wexp;
        sz      = int'(op[1:0]);
        valid   = (sz != 0);
        nb      = valid ? (1 << (sz - 1)) : 1;
        mis     = valid && ((a % nb) != 0);
        bus_acc = valid && !mis;

        start = 1'b1; opc_biu = op; ld_unsigned = u; addr = a; data_tobiu = wd;
        k = cyc;
        @(posedge clk); #1;
        start = 1'b0; opc_biu = 3'($urandom); addr = $urandom; data_tobiu = $urandom;

        e.mis = mis;
        e.flt = bus_acc && (mode != 0);
        e.cyc = !bus_acc ? k + 1 : (mode == 3) ? k + 1 + TO : k + 2 + dly;
        if (bus_acc && op[2] && mode == 0) begin
            lane = rd >> (8 * (a % 4));
            if (nb == 1) begin
                ld = lane % 256;
                if (!u && ld >= 128) ld = ld - 256;
            end else if (nb == 2) begin
                ld = lane % 65536;
                if (!u && ld >= 32768) ld = ld - 65536;
            end else ld = lane;
            model_data = ld;
        end
        e.data = model_data;
        sb.push_back(e);

        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("req_first_cycle", 32'(bus_req), 32'(bus_acc));
        if (bus_acc) begin
            strb = op[2] ? 32'd0 : (((32'd1 << nb) - 32'd1) << (a % 4));
            wexp = (nb == 1) ? (wd % 256) * 32'h01010101 :
                   (nb == 2) ? (wd % 65536) * 32'h00010001 : wd;
            chk("bus_addr", bus_addr, a - (a % 4));
            chk("bus_we", 32'(bus_we), 32'(!op[2]));
            chk("bus_wstrb", 32'(bus_wstrb), strb);
            if (!op[2]) chk("bus_wdata", bus_wdata, wexp);
            if (mode != 3) begin
                for (int i = 0; i < dly; i++) begin
                    start = poke; opc_biu = 3'b101; addr = 32'h0;
                    @(posedge clk); #1;
                    start = 1'b0;
                    chk("req_held", 32'(bus_req), 32'd1);
                    chk("bus_addr_stable", bus_addr, a - (a % 4));
                end
                bus_ack = (mode != 1); bus_err = (mode != 0); bus_rdata = rd;
                @(posedge clk); #1;
                bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
            end
        end
        w = 0;
        while (busy && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        if (busy) chk("busy_stuck", 32'(busy), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, mode;
        logic [2:0] op;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_biu", data_biu, 32'd0);
        chk("rst_ctrl", 32'({rdy_biu, busy, misalign, acc_fault, bus_req, bus_we}), 32'd0);
        chk("rst_bus", bus_addr | bus_wdata | 32'(bus_wstrb), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_access(3'b101, 1'b0, 32'h1003, 32'h0, 0, 0, 32'h80AA5511, 1'b0);
        chk("r8_sext", data_biu, 32'hFFFFFF80);
        do_access(3'b101, 1'b1, 32'h1003, 32'h0, 0, 0, 32'h80AA5511, 1'b0);
        chk("r8_zext", data_biu, 32'h00000080);
        do_access(3'b010, 1'b0, 32'h2002, 32'h1234ABCD, 0, 1, 32'h0, 1'b1);
        do_access(3'b111, 1'b0, 32'h3001, 32'h0, 0, 0, 32'h0, 1'b0);
        chk("misalign_keeps_data", data_biu, 32'h00000080);
        do_access(3'b111, 1'b0, 32'h4000, 32'h0, 3, 0, 32'h0, 1'b0);
        do_access(3'b111, 1'b0, 32'h4000, 32'h0, 2, 0, 32'hDEADBEEF, 1'b0);
        chk("fault_keeps_data", data_biu, 32'h00000080);
        do_access(3'b110, 1'b0, 32'h5002, 32'h0, 0, TO - 1, 32'h8001_7FFF, 1'b1);
        do_access(3'b100, 1'b0, 32'h6000, 32'h0, 0, 0, 32'h0, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus_ack = 1'b1; bus_err = $urandom_range(0, 1) == 1; bus_rdata = $urandom;
                @(posedge clk); #1;
                bus_ack = 1'b0; bus_err = 1'b0;
            end
            op = 3'($urandom);
            r  = $urandom_range(0, 9);
            mode = (r < 6 || r == 9) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3;
            do_access(op, 1'($urandom), $urandom, $urandom, mode, $urandom_range(0, TO - 1),
                      $urandom, $urandom_range(0, 1) == 1);
        end

        // Reset in the middle of a bus access
        start = 1'b1; opc_biu = 3'b111; addr = 32'h100;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mid_rst_req_before", 32'(bus_req), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        model_data = '0;
        chk("mid_rst_req_dropped", 32'(bus_req), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", data_biu, model_data);
        rst = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        repeat (3) begin
            chk("mid_rst_no_rdy", 32'(rdy_biu), 32'd0);
            @(posedge clk); #1;
        end
        chk("mid_rst_data_after", data_biu, model_data);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
